// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types and constants for the APB master bridge.
package apb_bridge_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   localparam logic SLV0 = 1'b0;
   localparam logic SLV1 = 1'b1;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: picks the selected completer's PREADY, PRDATA and PSLVERR.
module apb_slave_mux
   import apb_bridge_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              idx_i,
   input  logic [1:0]        pready_i,
   input  logic [DATA_W-1:0] prdata0_i,
   input  logic [DATA_W-1:0] prdata1_i,
   input  logic [1:0]        pslverr_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              slverr_o
);
   assign ready_o  = (idx_i == SLV1) ? pready_i[1] : pready_i[0];
   assign rdata_o  = (idx_i == SLV1) ? prdata1_i : prdata0_i;
   assign slverr_o = (idx_i == SLV1) ? pslverr_i[1] : pslverr_i[0];
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB requester for two completers
// with address decode, PREADY timeout and registered response.
module apb_master_bridge
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SEL_BIT = 12,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [1:0]        PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [1:0]        PREADY,
   input  logic [DATA_W-1:0] PRDATA0,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [1:0]        PSLVERR
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   state_t state_q, state_d;
   logic idx_q, idx_d, write_q, write_d, penable_q, penable_d, valid_q, valid_d;
   logic err_q, err_d, to_q, to_d;
   logic [1:0] psel_q, psel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic sel_ready, sel_err, accept, dec_err, tmo, done, enter;
   logic [DATA_W-1:0] sel_rdata;

   apb_slave_mux #(.DATA_W(DATA_W)) u_mux (
      .idx_i(idx_q), .pready_i(PREADY), .prdata0_i(PRDATA0), .prdata1_i(PRDATA1),
      .pslverr_i(PSLVERR), .ready_o(sel_ready), .rdata_o(sel_rdata), .slverr_o(sel_err)
   );

   assign cmd_ready = state_q == IDLE;
   assign accept    = cmd_valid && cmd_ready;
   assign dec_err   = (cmd_addr >> (SEL_BIT + 1)) != '0;
   assign done      = state_q == ACCESS && sel_ready;
   assign tmo       = TIMEOUT != 0 && state_q == ACCESS && !sel_ready && cnt_q == CW'(TIMEOUT - 1);
   assign enter     = state_d == RESP && state_q != RESP;

   always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = dec_err ? RESP : SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (done || tmo) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output registers load their next value from the next state so every APB pin is a flop.
   always_comb begin
      write_d   = accept ? cmd_write : write_q;
      addr_d    = accept ? cmd_addr : addr_q;
      wdata_d   = accept ? cmd_wdata : wdata_q;
      idx_d     = accept ? cmd_addr[SEL_BIT] : idx_q;
      psel_d    = (state_d == SETUP || state_d == ACCESS) ? (idx_d ? 2'b10 : 2'b01) : 2'b00;
      penable_d = state_d == ACCESS;
      valid_d   = state_d == RESP;
      cnt_d     = (state_q == ACCESS && state_d == ACCESS) ? cnt_q + 1'b1 : '0;
      rdata_d   = !enter ? rdata_q : (done && !write_q) ? sel_rdata : '0;
      err_d     = !enter ? err_q : done ? sel_err : 1'b1;
      to_d      = enter ? tmo : to_q;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         {idx_q, write_q, penable_q, valid_q, err_q, to_q} <= '0;
         psel_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         {idx_q, write_q, penable_q, valid_q, err_q, to_q} <= {idx_d, write_d, penable_d, valid_d, err_d, to_d};
         psel_q  <= psel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = write_q;
   assign PADDR       = addr_q;
   assign PWDATA      = wdata_q;
   assign rsp_valid   = valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = to_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB bridge against two modelled completers.
module tb_apb_master_bridge;
   logic PCLK = 1'b0, PRESET = 1'b1, cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA0 = '0, PRDATA1 = '0;
   logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE;
   logic [31:0] rsp_rdata, PADDR, PWDATA;
   logic [1:0] PSEL, PREADY, PSLVERR = '0;
   int vecs = 0, errs = 0, bad_bus = 0, acc_cnt = 0;
   int wait_n[2] = '{0, 0};
   int psel_n, lat;

   apb_master_bridge dut (
      .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
      .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Completer model: ready after wait_n[s] ACCESS cycles with PREADY low.
   assign PREADY = {PSEL[1] && PENABLE && acc_cnt >= wait_n[1],
                    PSEL[0] && PENABLE && acc_cnt >= wait_n[0]};
   always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
   always @(negedge PCLK) if (PSEL == 2'b11 || (PENABLE && PSEL == 2'b00)) bad_bus++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge PCLK);
      #1;
   endtask

   task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int pn, output int lt);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
      step;
      cmd_valid = 1'b0;
      pn = 0; lt = 0;
      while (!rsp_valid && lt < 64) begin
         if (PSEL != 2'b00) pn++;
         lt++;
         step;
      end
      chk("rsp_seen", rsp_valid, 1);
   endtask

   task automatic finish_rsp;
      rsp_ready = 1'b1;
      step;
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("ready_back", cmd_ready, 1);
   endtask

   initial begin
      step; step;
      PRESET = 1'b0;
      chk("rst_psel", PSEL, 0);
      chk("rst_pen", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", {rsp_err, rsp_timeout}, 0);
      chk("rst_cmd_ready", cmd_ready, 1);

      // write to slave 0, zero wait states, phase by phase
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
      PRDATA0 = 32'h5555AAAA;
      step;
      cmd_valid = 1'b0;
      chk("wr_setup_psel", PSEL, 2'b01);
      chk("wr_setup_pen", PENABLE, 0);
      chk("wr_setup_ctl", {PWRITE, cmd_ready}, 2'b10);
      chk("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
      step;
      chk("wr_acc_psel", PSEL, 2'b01);
      chk("wr_acc_pen", PENABLE, 1);
      chk("wr_acc_paddr", PADDR, 32'h10);
      step;
      chk("wr_resp_bus", {PSEL, PENABLE}, 0);
      chk("wr_resp_valid", rsp_valid, 1);
      chk("wr_resp_err", {rsp_err, rsp_timeout}, 0);
      chk("wr_resp_rdata", rsp_rdata, 0);
      finish_rsp;

      // read slave 1 with 3 wait states; slave 0 error/data must be ignored
      wait_n[1] = 3; PRDATA1 = 32'h12345678; PRDATA0 = 32'hBAD0BAD0; PSLVERR = 2'b01;
      run_cmd(1'b0, 32'h1010, 32'h0, psel_n, lat);
      chk("rd1_psel_cycles", psel_n, 5);
      chk("rd1_latency", lat, 5);
      chk("rd1_rdata", rsp_rdata, 32'h12345678);
      chk("rd1_err", {rsp_err, rsp_timeout}, 0);
      finish_rsp;
      PSLVERR = 2'b00;

      // decode error: bit above SEL_BIT set
      run_cmd(1'b0, 32'h2000, 32'h0, psel_n, lat);
      chk("dec_psel_cycles", psel_n, 0);
      chk("dec_latency", lat, 0);
      chk("dec_err", {rsp_err, rsp_timeout}, 2'b10);
      chk("dec_rdata", rsp_rdata, 0);
      finish_rsp;

      // slave 0 never ready: abort after 16 ACCESS cycles
      wait_n[0] = 1000;
      run_cmd(1'b0, 32'h20, 32'h0, psel_n, lat);
      chk("tmo_psel_cycles", psel_n, 17);
      chk("tmo_latency", lat, 17);
      chk("tmo_err", {rsp_err, rsp_timeout}, 2'b11);
      chk("tmo_rdata", rsp_rdata, 0);
      chk("tmo_bus", {PSEL, PENABLE}, 0);
      finish_rsp;

      // write with PSLVERR from slave 1, response back-pressured for 4 cycles
      wait_n[1] = 0; PSLVERR = 2'b10;
      run_cmd(1'b1, 32'h1004, 32'hCAFE0001, psel_n, lat);
      chk("slverr_latency", lat, 2);
      PSLVERR = 2'b00;
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_err", {rsp_err, rsp_timeout, rsp_rdata}, {2'b10, 32'h0});
         chk("hold_cmd_ready", cmd_ready, 0);
         step;
      end
      finish_rsp;

      // reset during ACCESS
      wait_n[0] = 1000;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
      step;
      cmd_valid = 1'b0;
      step;
      chk("rst_mid_pen_before", PENABLE, 1);
      PRESET = 1'b1;
      step;
      chk("rst_mid_bus", {PSEL, PENABLE}, 0);
      chk("rst_mid_valid", rsp_valid, 0);
      chk("rst_mid_paddr", PADDR, 0);
      PRESET = 1'b0;
      step;
      chk("rst_mid_cmd_ready", cmd_ready, 1);

      // recovery: slave 0 read with one wait state
      wait_n[0] = 1; PRDATA0 = 32'hCAFEF00D;
      run_cmd(1'b0, 32'h44, 32'h0, psel_n, lat);
      chk("rd0_latency", lat, 3);
      chk("rd0_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("rd0_err", {rsp_err, rsp_timeout}, 0);
      finish_rsp;

      chk("bus_rules", bad_bus, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
